// File: rtl/gzip_stream_pkg.sv
// Shared widths, buffer-entry type and byte-swap helper for the gzip output stream path.
package gzip_stream_pkg;

  localparam int GZ_DATA_WIDTH      = 32;
  localparam int GZ_CNT_WIDTH       = 24;
  localparam int GZ_FRAME_CNT_WIDTH = 16;

  typedef struct packed {
    logic [GZ_DATA_WIDTH-1:0] data;
    logic                     last;
  } gz_beat_t;

  // Reverses byte order: byte i moves to byte (N-1-i).
  function automatic logic [GZ_DATA_WIDTH-1:0] gz_byte_swap(input logic [GZ_DATA_WIDTH-1:0] d);
    logic [GZ_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < GZ_DATA_WIDTH / 8; i++) begin
      r[i*8 +: 8] = d[(GZ_DATA_WIDTH/8-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gzip_skid_buf2.sv
// Two-entry circular buffer; the head entry is presented continuously, the tail is filled on push.
module gzip_skid_buf2
  import gzip_stream_pkg::*;
#(
  parameter type T = gz_beat_t
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       i_push,
  input  T           i_push_entry,
  input  logic       i_pop,
  output logic [1:0] o_occ,
  output logic       o_valid,
  output T           o_head
);

  T           r_ent [2];
  logic       r_head_ptr;
  logic [1:0] r_occ;
  logic       r_valid;
  logic       w_wr_ptr;
  logic [1:0] w_occ_next;

  // Writes land one slot past the head when an entry is held, so the head never moves under a stall.
  assign w_wr_ptr   = r_head_ptr ^ r_occ[0];
  assign w_occ_next = r_occ + {1'b0, i_push} - {1'b0, i_pop};

  always_ff @(posedge clk) begin
    if (srst) begin
      r_ent[0]   <= '0;
      r_ent[1]   <= '0;
      r_head_ptr <= 1'b0;
      r_occ      <= 2'd0;
      r_valid    <= 1'b0;
    end else begin
      if (i_push) begin
        r_ent[w_wr_ptr] <= i_push_entry;
      end
      if (i_pop) begin
        r_head_ptr <= ~r_head_ptr;
      end
      r_occ   <= w_occ_next;
      r_valid <= (w_occ_next != 2'd0);
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = r_valid;
  assign o_head  = r_ent[r_head_ptr];

endmodule

// File: rtl/gzip_out_axis_bridge.sv
// Drains the Deflate output FIFO (1-cycle read latency) into an AXI-Stream master with
// optional byte swap and per-frame beat/frame statistics.
module gzip_out_axis_bridge
  import gzip_stream_pkg::*;
#(
  parameter int DATA_WIDTH      = GZ_DATA_WIDTH,
  parameter int CNT_WIDTH       = GZ_CNT_WIDTH,
  parameter int FRAME_CNT_WIDTH = GZ_FRAME_CNT_WIDTH
) (
  input  logic                       core_clock,
  input  logic                       bus_reset,
  input  logic                       fifo_empty,
  output logic                       fifo_rden,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       fifo_last,
  input  logic                       swap_bytes,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [CNT_WIDTH-1:0]       frame_words,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frames_sent
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  beat_t                      w_push_entry;
  beat_t                      w_head;
  logic [DATA_WIDTH-1:0]      w_swapped;
  logic [1:0]                 w_occ;
  logic                       w_valid;
  logic                       w_pop;
  logic [2:0]                 w_occ_after;
  logic [CNT_WIDTH-1:0]       w_run_inc;
  logic                       r_pend;
  logic [CNT_WIDTH-1:0]       r_run_cnt;
  logic [CNT_WIDTH-1:0]       r_frame_words;
  logic                       r_frame_done;
  logic [FRAME_CNT_WIDTH-1:0] r_frames_sent;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_swap
    assign w_swapped[gi*8 +: 8] = fifo_data[(NBYTES-1-gi)*8 +: 8];
  end

  // swap_bytes is applied to the word arriving now, not to the word requested now.
  assign w_push_entry = {(swap_bytes ? w_swapped : fifo_data), fifo_last};

  gzip_skid_buf2 #(
    .T(beat_t)
  ) u_buf (
    .clk          (core_clock),
    .srst         (bus_reset),
    .i_push       (r_pend),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_occ        (w_occ),
    .o_valid      (w_valid),
    .o_head       (w_head)
  );

  assign w_pop = w_valid & m_axis_tready;

  // Only request when the word landing next cycle is guaranteed a free slot.
  assign w_occ_after = {1'b0, w_occ} + {2'b0, r_pend} - {2'b0, w_pop};
  assign fifo_rden   = ~fifo_empty & ~bus_reset & (w_occ_after <= 3'd1);

  always_ff @(posedge core_clock) begin
    if (bus_reset) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= fifo_rden;
    end
  end

  assign w_run_inc = (r_run_cnt == {CNT_WIDTH{1'b1}}) ? r_run_cnt : r_run_cnt + CNT_WIDTH'(1);

  always_ff @(posedge core_clock) begin
    if (bus_reset) begin
      r_run_cnt     <= '0;
      r_frame_words <= '0;
      r_frame_done  <= 1'b0;
      r_frames_sent <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_pop) begin
        if (w_head.last) begin
          r_frame_words <= w_run_inc;
          r_run_cnt     <= '0;
          r_frames_sent <= r_frames_sent + FRAME_CNT_WIDTH'(1);
          r_frame_done  <= 1'b1;
        end else begin
          r_run_cnt <= w_run_inc;
        end
      end
    end
  end

  assign m_axis_tdata  = w_head.data;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tvalid = w_valid;
  assign frame_words   = r_frame_words;
  assign frame_done    = r_frame_done;
  assign frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_gzip_out_axis_bridge.sv
// Scoreboard bench: a FIFO model feeds the bridge, expected beats are queued at capture time.
`timescale 1ns/1ps
module tb_gzip_out_axis_bridge;
  import gzip_stream_pkg::*;

  localparam int DW = 32;
  localparam int CW = 24;
  localparam int FW = 16;

  logic          core_clock    = 1'b0;
  logic          bus_reset     = 1'b1;
  logic          fifo_empty    = 1'b1;
  logic          fifo_rden;
  logic [DW-1:0] fifo_data     = '0;
  logic          fifo_last     = 1'b0;
  logic          swap_bytes    = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [CW-1:0] frame_words;
  logic          frame_done;
  logic [FW-1:0] frames_sent;

  gz_beat_t fifo_q[$];
  gz_beat_t exp_q[$];
  int       vec_cnt    = 0;
  int       err_cnt    = 0;
  int       n_pops     = 0;
  int       exp_frames = 0;
  bit       rand_empty = 1'b0;

  gzip_out_axis_bridge #(
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW),
    .FRAME_CNT_WIDTH (FW)
  ) dut (
    .core_clock    (core_clock),
    .bus_reset     (bus_reset),
    .fifo_empty    (fifo_empty),
    .fifo_rden     (fifo_rden),
    .fifo_data     (fifo_data),
    .fifo_last     (fifo_last),
    .swap_bytes    (swap_bytes),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_words   (frame_words),
    .frame_done    (frame_done),
    .frames_sent   (frames_sent)
  );

  always #5 core_clock = ~core_clock;

  function automatic logic [31:0] tb_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Core FIFO model: word appears 1 cycle after rden; expectation is queued when the DUT captures it.
  bit       drove = 1'b0;
  gz_beat_t drv_beat;
  always begin : fifo_model
    bit       rd;
    gz_beat_t e;
    @(negedge core_clock);
    if (drove && !bus_reset) begin
      e.data = swap_bytes ? tb_swap(drv_beat.data) : drv_beat.data;
      e.last = drv_beat.last;
      exp_q.push_back(e);
    end
    drove = 1'b0;
    rd = fifo_rden;
    @(posedge core_clock);
    #1;
    if (bus_reset) begin
      fifo_q.delete();
      fifo_empty = 1'b1;
    end else begin
      if (rd && fifo_q.size() > 0) begin
        drv_beat  = fifo_q.pop_front();
        fifo_data = drv_beat.data;
        fifo_last = drv_beat.last;
        drove     = 1'b1;
      end
      fifo_empty = (fifo_q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
    end
  end

  // Output monitor: beat order/content, occupancy bound, hold-under-stall.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge core_clock) begin : monitor
    gz_beat_t e;
    if (!bus_reset) begin
      vec_cnt++;
      if (dut.u_buf.o_occ > 2'd2 || $isunknown(dut.u_buf.o_occ)) begin
        err_cnt++;
        $display("FAIL occ_bound: occ=%0d, required <= 2", dut.u_buf.o_occ);
      end
      if (prev_hold) begin
        vec_cnt++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          err_cnt++;
          $display("FAIL axis_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        n_pops++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL beat_unexpected: tdata=%h tlast=%b, required no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
            err_cnt++;
            $display("FAIL beat: tdata=%h tlast=%b, required %h %b", m_axis_tdata, m_axis_tlast, e.data, e.last);
          end
        end
      end
      prev_hold = (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0);
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge core_clock);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || fifo_rden !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_stream: tvalid=%b tdata=%h tlast=%b rden=%b, required 0 0 0 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_rden);
    end
    vec_cnt++;
    if (frame_words !== '0 || frame_done !== 1'b0 || frames_sent !== '0) begin
      err_cnt++;
      $display("FAIL reset_counters: words=%0d done=%b frames=%0d, required 0 0 0", frame_words, frame_done, frames_sent);
    end
    @(posedge core_clock);
    #1;
    bus_reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    gz_beat_t b;
    int       t;
    int       n_done;
    logic     exp_v;
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b1;
    swap_bytes    = 1'b0;
    @(negedge core_clock);
    for (int i = 1; i <= 8; i++) begin
      b.data = 32'(i);
      b.last = (i == 8);
      fifo_q.push_back(b);
    end
    exp_frames++;
    t = 0;
    do begin
      @(negedge core_clock);
      t++;
    end while (fifo_rden !== 1'b1 && t < 20);
    vec_cnt++;
    if (fifo_rden !== 1'b1) begin
      err_cnt++;
      $display("FAIL stream_rden_timeout: rden=%b after %0d cycles, required 1", fifo_rden, t);
    end
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge core_clock);
      exp_v = (k >= 2 && k <= 9);
      vec_cnt++;
      if (m_axis_tvalid !== exp_v) begin
        err_cnt++;
        $display("FAIL stream_tvalid: cycle %0d tvalid=%b, required %b", k, m_axis_tvalid, exp_v);
      end
      exp_v = (k == 10);
      vec_cnt++;
      if (frame_done !== exp_v) begin
        err_cnt++;
        $display("FAIL stream_frame_done: cycle %0d frame_done=%b, required %b", k, frame_done, exp_v);
      end
      if (frame_done === 1'b1) n_done++;
    end
    vec_cnt++;
    if (n_done != 1 || frame_words !== 24'd8 || frames_sent !== 16'(exp_frames)) begin
      err_cnt++;
      $display("FAIL stream_stats: pulses=%0d words=%0d frames=%0d, required 1 8 %0d",
               n_done, frame_words, frames_sent, exp_frames);
    end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    gz_beat_t b;
    int       n_rd;
    int       n_beats;
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b0;
    @(negedge core_clock);
    for (int i = 0; i < 5; i++) begin
      b.data = 32'hB000_0001 + 32'(i);
      b.last = (i == 4);
      fifo_q.push_back(b);
    end
    exp_frames++;
    n_rd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge core_clock);
      if (fifo_rden === 1'b1) n_rd++;
    end
    vec_cnt++;
    if (n_rd != 2) begin
      err_cnt++;
      $display("FAIL bp_rden_count: rden pulses=%0d, required 2", n_rd);
    end
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hB000_0001 || m_axis_tlast !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_head: tvalid=%b tdata=%h tlast=%b, required 1 b0000001 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b1;
    n_beats = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge core_clock);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) n_beats++;
    end
    vec_cnt++;
    if (n_beats != 5) begin
      err_cnt++;
      $display("FAIL bp_drain: beats in 5 cycles=%0d, required 5", n_beats);
    end
    repeat (2) @(negedge core_clock);
    vec_cnt++;
    if (frame_words !== 24'd5 || frames_sent !== 16'(exp_frames)) begin
      err_cnt++;
      $display("FAIL bp_stats: words=%0d frames=%0d, required 5 %0d", frame_words, frames_sent, exp_frames);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_byte_swap();
    gz_beat_t b;
    int       t;
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b0;
    swap_bytes    = 1'b1;
    @(negedge core_clock);
    b.data = 32'h1122_3344; b.last = 1'b0; fifo_q.push_back(b);
    b.data = 32'h0102_0304; b.last = 1'b1; fifo_q.push_back(b);
    exp_frames++;
    t = 0;
    do begin
      @(posedge core_clock);
      #1;
      t++;
    end while (m_axis_tvalid !== 1'b1 && t < 20);
    // First word captured, second still in flight: flip swap so only the second is affected.
    swap_bytes    = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge core_clock);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h4433_2211) begin
      err_cnt++;
      $display("FAIL swap_on: tvalid=%b tdata=%h, required 1 44332211", m_axis_tvalid, m_axis_tdata);
    end
    @(negedge core_clock);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0102_0304 || m_axis_tlast !== 1'b1) begin
      err_cnt++;
      $display("FAIL swap_toggled: tvalid=%b tdata=%h tlast=%b, required 1 01020304 1",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    repeat (2) @(negedge core_clock);
    $display("test_byte_swap done");
  endtask

  task automatic test_single_beat();
    gz_beat_t b;
    int       t;
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b1;
    @(negedge core_clock);
    for (int i = 0; i < 3; i++) begin
      b.data = 32'hC000_0001 + 32'(i);
      b.last = 1'b1;
      fifo_q.push_back(b);
    end
    exp_frames += 3;
    t = 0;
    do begin
      @(negedge core_clock);
      t++;
    end while (frame_done !== 1'b1 && t < 20);
    vec_cnt++;
    if (frame_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_first_done: frame_done=%b after %0d cycles, required 1", frame_done, t);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge core_clock);
      vec_cnt++;
      if (frame_done !== (k < 3)) begin
        err_cnt++;
        $display("FAIL single_done_run: cycle +%0d frame_done=%b, required %b", k, frame_done, (k < 3));
      end
    end
    vec_cnt++;
    if (frame_words !== 24'd1 || frames_sent !== 16'(exp_frames)) begin
      err_cnt++;
      $display("FAIL single_stats: words=%0d frames=%0d, required 1 %0d", frame_words, frames_sent, exp_frames);
    end
    $display("test_single_beat done");
  endtask

  task automatic test_random();
    gz_beat_t b;
    int       base;
    int       t;
    base = n_pops;
    rand_empty = 1'b1;
    @(negedge core_clock);
    for (int i = 0; i < 1000; i++) begin
      b.data = $urandom;
      b.last = (i % 100 == 99);
      fifo_q.push_back(b);
    end
    exp_frames += 10;
    t = 0;
    while (n_pops - base < 1000 && t < 20000) begin
      @(posedge core_clock);
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
      swap_bytes    = 1'($urandom_range(0, 1));
      t++;
    end
    rand_empty    = 1'b0;
    m_axis_tready = 1'b1;
    swap_bytes    = 1'b0;
    vec_cnt++;
    if (n_pops - base != 1000) begin
      err_cnt++;
      $display("FAIL rand_beats: delivered=%0d in %0d cycles, required 1000", n_pops - base, t);
    end
    repeat (3) @(negedge core_clock);
    vec_cnt++;
    if (frames_sent !== 16'(exp_frames) || frame_words !== 24'd100 || exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rand_stats: frames=%0d words=%0d pending=%0d tvalid=%b, required %0d 100 0 0",
               frames_sent, frame_words, exp_q.size(), m_axis_tvalid, exp_frames);
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    gz_beat_t b;
    int       base;
    int       t;
    base = n_pops;
    @(posedge core_clock);
    #1;
    m_axis_tready = 1'b1;
    @(negedge core_clock);
    for (int i = 0; i < 8; i++) begin
      b.data = 32'hD000_0000 + 32'(i);
      b.last = 1'b0;
      fifo_q.push_back(b);
    end
    t = 0;
    while (n_pops - base < 2 && t < 30) begin
      @(posedge core_clock);
      #1;
      t++;
    end
    m_axis_tready = 1'b0;
    t = 0;
    while (!(dut.u_buf.o_occ == 2'd1 && dut.r_pend == 1'b1) && t < 10) begin
      @(posedge core_clock);
      #1;
      t++;
    end
    vec_cnt++;
    if (!(dut.u_buf.o_occ == 2'd1 && dut.r_pend == 1'b1)) begin
      err_cnt++;
      $display("FAIL rst_setup: occ=%0d pend=%b, required 1 1", dut.u_buf.o_occ, dut.r_pend);
    end
    bus_reset = 1'b1;
    @(negedge core_clock);
    vec_cnt++;
    if (fifo_rden !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_rden_gate: rden=%b with fifo_empty=%b, required 0", fifo_rden, fifo_empty);
    end
    @(negedge core_clock);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || fifo_rden !== 1'b0 ||
        frame_words !== '0 || frame_done !== 1'b0 || frames_sent !== '0) begin
      err_cnt++;
      $display("FAIL rst_mid_state: tvalid=%b tdata=%h rden=%b words=%0d done=%b frames=%0d, required all 0",
               m_axis_tvalid, m_axis_tdata, fifo_rden, frame_words, frame_done, frames_sent);
    end
    exp_q.delete();
    exp_frames = 0;
    @(posedge core_clock);
    #1;
    bus_reset     = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge core_clock);
    for (int i = 0; i < 3; i++) begin
      b.data = 32'hE000_0001 + 32'(i);
      b.last = (i == 2);
      fifo_q.push_back(b);
    end
    exp_frames = 1;
    t = 0;
    do begin
      @(negedge core_clock);
      t++;
    end while (frame_done !== 1'b1 && t < 20);
    vec_cnt++;
    if (frame_done !== 1'b1 || frame_words !== 24'd3 || frames_sent !== 16'(exp_frames)) begin
      err_cnt++;
      $display("FAIL rst_new_frame: done=%b words=%0d frames=%0d, required 1 3 1", frame_done, frame_words, frames_sent);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_byte_swap();
    test_single_beat();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge core_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not complete within 80000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
